// File: rtl/intr_pkg.sv
// intr_pkg: shared definitions for the processor-side interrupt host agent.
//   - Controller mode codes and configuration word tag
//   - Vector / end-of-interrupt signature constants
//   - Host FSM state encoding
//   - Helpers: vector signature check and EOI signature select
package intr_pkg;

    localparam logic [1:0] MODE_NONE     = 2'b00;
    localparam logic [1:0] MODE_POLL     = 2'b01;
    localparam logic [1:0] MODE_PRIO     = 2'b10;

    localparam logic [4:0] SIG_VEC_POLL  = 5'b01011;
    localparam logic [4:0] SIG_VEC_PRIO  = 5'b10011;
    localparam logic [4:0] SIG_EOI_POLL  = 5'b10100;
    localparam logic [4:0] SIG_EOI_PRIO  = 5'b01100;

    localparam logic [1:0] CFG_PRIO_TAG  = 2'b10;
    localparam logic [7:0] CFG_POLL_WORD = 8'h01;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG       = 4'd1,
        ST_WAIT_ACK1 = 4'd2,
        ST_CAPTURE   = 4'd3,
        ST_WAIT_ACK2 = 4'd4,
        ST_HANDOFF   = 4'd5,
        ST_SERVICE   = 4'd6,
        ST_EOI       = 4'd7,
        ST_HOLD      = 4'd8
    } host_state_e;

    // True when the upper five bits of a vector word carry the signature of the active mode.
    function automatic logic vec_sig_ok(input logic [1:0] mode, input logic [4:0] sig);
        logic ok_s;
        case (mode)
            MODE_POLL: ok_s = (sig == SIG_VEC_POLL);
            MODE_PRIO: ok_s = (sig == SIG_VEC_PRIO);
            default:   ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

    // Signature placed above the interrupt ID in the EOI word.
    function automatic logic [4:0] eoi_sig(input logic [1:0] mode);
        logic [4:0] sig_s;
        case (mode)
            MODE_PRIO: sig_s = SIG_EOI_PRIO;
            default:   sig_s = SIG_EOI_POLL;
        endcase
        return sig_s;
    endfunction

endpackage

// File: rtl/intr_cfg_writer.sv
// intr_cfg_writer: configuration word sequencer for the interrupt controller.
// Ports:
//   clk_in, rst_in  clock, synchronous active-low reset
//   start           1-cycle pulse: latch mode/priority and begin
//   mode, prio      requested mode and 8x3-bit priority order
//   ctrl_bus_oe     controller is driving the bus (stall writes)
//   wr, word        drive 'word' onto the bus this cycle
//   done            last word written (or mode rejected)
//   bad             mode is neither polling nor priority
//   mode_latched    mode captured at start
module intr_cfg_writer
    import intr_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [23:0] prio,
    input  logic        ctrl_bus_oe,
    output logic        wr,
    output logic [7:0]  word,
    output logic        done,
    output logic        bad,
    output logic [1:0]  mode_latched
);

    logic        active_r;
    logic [1:0]  idx_r;
    logic [1:0]  mode_r;
    logic [23:0] prio_r;
    logic        mode_ok_s;
    logic        last_s;

    // Sequencer state: latch the request on start, advance one word per unstalled write.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            active_r <= 1'b0;
            idx_r    <= 2'd0;
            mode_r   <= MODE_NONE;
            prio_r   <= 24'd0;
        end else if (start) begin
            active_r <= 1'b1;
            idx_r    <= 2'd0;
            mode_r   <= mode;
            prio_r   <= prio;
        end else if (done) begin
            active_r <= 1'b0;
            idx_r    <= 2'd0;
        end else if (wr) begin
            idx_r    <= idx_r + 2'd1;
        end
    end

    // Write qualification and completion; an unsupported mode finishes at once with no writes.
    always_comb begin
        mode_ok_s = (mode_r == MODE_POLL) || (mode_r == MODE_PRIO);
        wr        = active_r && mode_ok_s && !ctrl_bus_oe;
        last_s    = (mode_r == MODE_POLL) || (idx_r == 2'd3);
        done      = active_r && (!mode_ok_s || (wr && last_s));
        bad       = active_r && !mode_ok_s;
    end

    // Word mux: priority words pack two IDs, highest first, above the tag.
    always_comb begin
        word = 8'h00;
        if (mode_r == MODE_POLL) begin
            word = CFG_POLL_WORD;
        end else begin
            case (idx_r)
                2'd0:    word = {prio_r[23:18], CFG_PRIO_TAG};
                2'd1:    word = {prio_r[17:12], CFG_PRIO_TAG};
                2'd2:    word = {prio_r[11:6],  CFG_PRIO_TAG};
                2'd3:    word = {prio_r[5:0],   CFG_PRIO_TAG};
                default: word = 8'h00;
            endcase
        end
    end

    assign mode_latched = mode_r;

endmodule

// File: rtl/intr_host_if.sv
// intr_host_if: processor-side agent on the shared 8-bit interrupt bus.
// Programs the controller, acknowledges interrupts with two active-low ack
// pulses, checks the vector word, hands the ID to the core and issues EOI.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-low reset
//   intr_req_in, ctrl_bus_oe_in    controller interrupt pending / bus drive
//   bus_in, bus_out, bus_oe_out    resolved bus, our drive value and enable
//   intr_ack_n_out                 active-low ack / strobe to controller
//   cfg_start_in, cfg_mode_in,
//   cfg_prio_in, cfg_busy_out      configuration request and status
//   mode_out                       active mode (00 = unconfigured)
//   vec_valid_out, vec_id_out,
//   vec_ready_in                   valid/ready handoff of interrupt ID
//   isr_done_in                    core finished ISR
//   err_out                        bad signature, capture timeout or bad mode
// All outputs are registered.
module intr_host_if
    import intr_pkg::*;
#(
    parameter int ACK_DLY = 6,
    parameter int CAP_TMO = 16,
    parameter int HOLDOFF = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        intr_req_in,
    input  logic        ctrl_bus_oe_in,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        bus_oe_out,
    output logic        intr_ack_n_out,
    input  logic        cfg_start_in,
    input  logic [1:0]  cfg_mode_in,
    input  logic [23:0] cfg_prio_in,
    output logic        cfg_busy_out,
    output logic [1:0]  mode_out,
    output logic        vec_valid_out,
    output logic [2:0]  vec_id_out,
    input  logic        vec_ready_in,
    input  logic        isr_done_in,
    output logic        err_out
);

    // Terminal counts: each timed state lasts exactly N cycles.
    localparam logic [7:0] ACK_LAST  = 8'(ACK_DLY - 1);
    localparam logic [7:0] CAP_LAST  = 8'(CAP_TMO - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    host_state_e state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        match_r, match_s;
    logic [2:0]  id_s;
    logic [7:0]  bus_s;
    logic        oe_s, ack_n_s, err_s, busy_s, valid_s;
    logic [1:0]  mode_s;

    logic        cfg_start_s, cfg_wr_s, cfg_done_s, cfg_bad_s;
    logic [7:0]  cfg_word_s;
    logic [1:0]  cfg_mode_s;

    assign cfg_start_s = cfg_start_in && (state_r == ST_IDLE);

    intr_cfg_writer u_cfg_writer (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start        (cfg_start_s),
        .mode         (cfg_mode_in),
        .prio         (cfg_prio_in),
        .ctrl_bus_oe  (ctrl_bus_oe_in),
        .wr           (cfg_wr_s),
        .word         (cfg_word_s),
        .done         (cfg_done_s),
        .bad          (cfg_bad_s),
        .mode_latched (cfg_mode_s)
    );

    // State, counter and all outputs are registered from the next-state logic.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 8'd0;
            match_r        <= 1'b0;
            bus_out        <= 8'h00;
            bus_oe_out     <= 1'b0;
            intr_ack_n_out <= 1'b1;
            cfg_busy_out   <= 1'b0;
            mode_out       <= MODE_NONE;
            vec_valid_out  <= 1'b0;
            vec_id_out     <= 3'd0;
            err_out        <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            match_r        <= match_s;
            bus_out        <= bus_s;
            bus_oe_out     <= oe_s;
            intr_ack_n_out <= ack_n_s;
            cfg_busy_out   <= busy_s;
            mode_out       <= mode_s;
            vec_valid_out  <= valid_s;
            vec_id_out     <= id_s;
            err_out        <= err_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        match_s = match_r;
        id_s    = vec_id_out;
        bus_s   = 8'h00;
        oe_s    = 1'b0;
        ack_n_s = 1'b1;
        err_s   = 1'b0;
        mode_s  = mode_out;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 8'd0;
                if (cfg_start_in) begin
                    state_s = ST_CFG;
                end else if (intr_req_in && (mode_out != MODE_NONE)) begin
                    state_s = ST_WAIT_ACK1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CFG: begin
                if (cfg_wr_s) begin
                    bus_s = cfg_word_s;
                    oe_s  = 1'b1;
                end else begin
                    oe_s  = 1'b0;
                end
                err_s = cfg_bad_s;
                if (cfg_done_s) begin
                    mode_s  = cfg_mode_s;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CFG;
                end
            end
            ST_WAIT_ACK1: begin
                if (cnt_r == ACK_LAST) begin
                    ack_n_s = 1'b0;
                    cnt_s   = 8'd0;
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            ST_CAPTURE: begin
                if (ctrl_bus_oe_in) begin
                    cnt_s   = 8'd0;
                    state_s = ST_WAIT_ACK2;
                    if (vec_sig_ok(mode_out, bus_in[7:3])) begin
                        match_s = 1'b1;
                        id_s    = bus_in[2:0];
                    end else begin
                        match_s = 1'b0;
                        err_s   = 1'b1;
                    end
                end else if (cnt_r == CAP_LAST) begin
                    match_s = 1'b0;
                    err_s   = 1'b1;
                    cnt_s   = 8'd0;
                    state_s = ST_WAIT_ACK2;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            ST_WAIT_ACK2: begin
                if (cnt_r == ACK_LAST) begin
                    ack_n_s = 1'b0;
                    cnt_s   = 8'd0;
                    state_s = match_r ? ST_HANDOFF : ST_HOLD;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            ST_HANDOFF: begin
                // An ISR completing in the same cycle as acceptance goes straight to EOI.
                if (vec_ready_in) begin
                    state_s = isr_done_in ? ST_EOI : ST_SERVICE;
                end else begin
                    state_s = ST_HANDOFF;
                end
            end
            ST_SERVICE: begin
                if (isr_done_in) begin
                    state_s = ST_EOI;
                end else begin
                    state_s = ST_SERVICE;
                end
            end
            ST_EOI: begin
                if (!ctrl_bus_oe_in) begin
                    bus_s   = {eoi_sig(mode_out), vec_id_out};
                    oe_s    = 1'b1;
                    ack_n_s = 1'b0;
                    cnt_s   = 8'd0;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_EOI;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_s   = 8'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            default: begin
                cnt_s   = 8'd0;
                state_s = ST_IDLE;
            end
        endcase
        valid_s = (state_s == ST_HANDOFF);
        // Busy also covers the cycle the final configuration word is on the bus.
        busy_s  = (state_s == ST_CFG) || (state_r == ST_CFG);
    end

endmodule

// File: doc/intr_host_if.md
Name: intr_host_if

Overview:
Processor-side agent for the interrupt controller; sits directly downstream of it on the shared 8-bit interrupt bus.
- Programs controller mode and priority order.
- Answers intr_out with the two-step active-low acknowledge, captures and checks the vector word, then hands the interrupt ID to the core.
- Issues the end-of-interrupt (EOI) word once the core finishes its ISR.

Parameters:
ACK_DLY, 6, cycles between an event (request seen / vector captured) and the ack pulse; must be at least 1
CAP_TMO, 16, cycles to wait for controller to drive the vector before error
HOLDOFF, 4, idle cycles after EOI before a new request is accepted

Ports:
clk_in  input  1  single clock; all logic rising-edge
rst_in  input  1  synchronous, active-low reset
intr_req_in  input  1  controller intr_out (interrupt pending)
ctrl_bus_oe_in  input  1  controller bus_oe (1 = controller drives bus)
bus_in  input  8  resolved interrupt bus value
bus_out  output  8  value this block drives on bus
bus_oe_out  output  1  1 = this block drives bus
intr_ack_n_out  output  1  to controller intr_in; active-low ack/strobe
cfg_start_in  input  1  1-cycle pulse: program controller
cfg_mode_in  input  2  01 polling, 10 priority
cfg_prio_in  input  24  priority order, 8x3-bit IDs; [23:21] highest
cfg_busy_out  output  1  configuration in progress
mode_out  output  2  active mode register (00 = unconfigured)
vec_valid_out  output  1  captured interrupt available to core
vec_id_out  output  3  interrupt ID
vec_ready_in  input  1  core accepts vector (valid/ready)
isr_done_in  input  1  1-cycle pulse: core finished ISR
err_out  output  1  1-cycle pulse: bad signature or capture timeout

Behaviour:
- Reset (rst_in=0 at a clock edge) puts every output in its reset state: bus_out=0, bus_oe_out=0, intr_ack_n_out=1, cfg_busy_out=0, mode_out=00, vec_valid_out=0, vec_id_out=0, err_out=0. FSM goes to IDLE. Reset mid-handshake aborts it with no EOI.
- States: IDLE, CFG, WAIT_ACK1, CAPTURE, WAIT_ACK2, HANDOFF, SERVICE, EOI, HOLD.
- IDLE:
  - cfg_start_in wins over intr_req_in.
  - cfg_start_in is ignored outside IDLE.
  - intr_req_in is ignored while mode_out=00.
- CFG: cfg_busy_out=1; bus_oe_out=1 only while ctrl_bus_oe_in=0 (otherwise stall).
  - Mode 01: drive 8'h01 for 1 cycle.
  - Mode 10: drive 4 consecutive words {prio[23:21],prio[20:18],2'b10}, then [17:15],[14:12], then [11:9],[8:6], then [5:3],[2:0].
  - Other modes: no writes; err_out pulse.
  - intr_ack_n_out stays 1 throughout.
  - On completion mode_out=cfg_mode_in; return to IDLE.
- intr_req_in=1 in IDLE -> WAIT_ACK1. Count ACK_DLY cycles, then drive intr_ack_n_out=0 for exactly 1 cycle -> CAPTURE.
- CAPTURE: sample bus_in on the first cycle ctrl_bus_oe_in=1.
  - Required signature: bus_in[7:3]=5'b01011 (polling) or 5'b10011 (priority).
  - Match: vec_id_out=bus_in[2:0].
  - Mismatch, or CAP_TMO cycles with no drive: err_out pulse.
  - Either way -> WAIT_ACK2.
- WAIT_ACK2: after ACK_DLY cycles, 1-cycle ack pulse.
  - Then HANDOFF if the signature matched.
  - Otherwise HOLD (no EOI).
- HANDOFF: vec_valid_out=1, held with a stable ID until vec_ready_in=1 -> SERVICE.
- SERVICE: wait for isr_done_in.
  - isr_done_in coincident with the accepting vec_ready_in counts.
  - isr_done_in in any other state is ignored.
- EOI: once ctrl_bus_oe_in=0, drive bus_out={SIG,id} with bus_oe_out=1 and intr_ack_n_out=0 for 1 cycle. SIG=5'b10100 (polling), 5'b01100 (priority). Next cycle bus_oe_out=0 -> HOLD.
- HOLD: HOLDOFF cycles with intr_req_in ignored -> IDLE.
- Invariants:
  - bus_oe_out=1 and ctrl_bus_oe_in=1 never in the same cycle.
  - Ack pulses are always exactly 1 cycle wide.

Decomposition:
- Package intr_pkg:
  - Mode codes MODE_POLL=2'b01, MODE_PRIO=2'b10.
  - Signature constants SIG_VEC_POLL, SIG_VEC_PRIO, SIG_EOI_POLL, SIG_EOI_PRIO.
  - CFG_PRIO_TAG=2'b10.
  - Host FSM state enum.
- Sub-module intr_cfg_writer: the CFG word sequencer (counter + word mux + stall on ctrl_bus_oe_in), started and finished by a pulse.

Test Plan:
- Polling config: cfg_mode 01 -> one cycle bus_out=8'h01, oe=1, ack_n=1; mode_out=01.
- Priority config with order 5,3,7,0,4,2,6,1 -> words 8'b10101110, 8'b11100010, 8'b10001010, 8'b11000110 on 4 consecutive cycles.
- Polling service: intr_req=1 -> ack at +6; bus 8'b01011_011 -> vec_id=3. Second ack after 6 more cycles; after isr_done, EOI 8'b10100_011 with one ack cycle.
- Priority bad signature: bus 8'b01011_101 in priority mode -> err_out pulse, second ack still issued, no vec_valid, no EOI.
- Capture timeout: ctrl_bus_oe held 0 for 16 cycles -> err_out; intr_req held high during HOLD is not serviced until HOLD ends.
- Reset during SERVICE (rst_in=0 one cycle) -> all outputs return to reset values; mode_out=00; later intr_req ignored until reconfigured.
